// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB, decodes the opcode into datapath
// controls, and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic             RegDst,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instCount
);

  typedef enum logic [2:0] {
    StIf  = 3'b000,
    StId  = 3'b001,
    StExe = 3'b010,
    StMem = 3'b011,
    StWb  = 3'b100,
    StHlt = 3'b101
  } state_e;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpHalt = 6'b111111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_add, is_sub, is_addi, is_ori, is_sw, is_lw, is_beq, is_j, is_halt;
  logic is_alu, is_defined;
  logic pc_we, ir_we, reg_we, mem_we;
  logic [1:0] pc_src;

  assign is_add     = (opcode == OpAdd);
  assign is_sub     = (opcode == OpSub);
  assign is_addi    = (opcode == OpAddi);
  assign is_ori     = (opcode == OpOri);
  assign is_sw      = (opcode == OpSw);
  assign is_lw      = (opcode == OpLw);
  assign is_beq     = (opcode == OpBeq);
  assign is_j       = (opcode == OpJ);
  assign is_halt    = (opcode == OpHalt);
  assign is_alu     = is_add | is_sub | is_addi | is_ori;
  assign is_defined = is_alu | is_sw | is_lw | is_beq | is_j | is_halt;

  // Decode outputs depend on the opcode only, so they are valid in every state.
  assign RegDst    = is_add | is_sub;
  assign ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
  assign ALUOp     = (is_sub | is_beq) ? 3'b001 : (is_ori ? 3'b011 : 3'b000);
  assign ExtSel    = ~is_ori;
  assign DBDataSrc = is_lw;

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    pc_src  = 2'b00;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    mRD     = 1'b0;
    unique case (state_q)
      StIf: begin
        ir_we   = 1'b1;
        state_d = StId;
      end
      StId: begin
        if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          state_d = StIf;
        end else if (is_halt) begin
          state_d = StHlt;
        end else if (!is_defined) begin
          pc_we   = 1'b1;
          state_d = StIf;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        if (is_beq) begin
          pc_we   = 1'b1;
          pc_src  = zero ? 2'b01 : 2'b00;
          state_d = StIf;
        end else if (is_sw || is_lw) begin
          state_d = StMem;
        end else if (is_alu) begin
          state_d = StWb;
        end else begin
          state_d = StIf;
        end
      end
      StMem: begin
        if (is_lw) begin
          mRD     = 1'b1;
          state_d = StWb;
        end else begin
          mem_we  = 1'b1;
          pc_we   = 1'b1;
          state_d = StIf;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        mRD     = is_lw;
        state_d = StIf;
      end
      StHlt:   state_d = StHlt;
      default: state_d = StIf;
    endcase
    // Holding reset suppresses every write so an aborted instruction leaves no trace.
    if (!Reset) begin
      pc_we  = 1'b0;
      pc_src = 2'b00;
      ir_we  = 1'b0;
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign cnt_d = cnt_q + CNT_W'(pc_we);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCWre     = pc_we;
  assign PCSrc     = pc_src;
  assign IRWre     = ir_we;
  assign RegWre    = reg_we;
  assign mWR       = mem_we;
  assign state     = state_q;
  assign halted    = (state_q == StHlt);
  assign instCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors for each instruction
// class, reset behaviour, halt and counter wrap (second instance with CNT_W=2).
module tb_multicycle_control_unit;
  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;

  logic        PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, halted;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp, state;
  logic [15:0] instCount;

  logic        PCWre_w, IRWre_w, RegWre_w, RegDst_w, ALUSrcB_w, ExtSel_w, mRD_w, mWR_w;
  logic        DBDataSrc_w, halted_w;
  logic [1:0]  PCSrc_w;
  logic [2:0]  ALUOp_w, state_w;
  logic [1:0]  instCount_w;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;

  multicycle_control_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .state(state), .halted(halted), .instCount(instCount)
  );

  multicycle_control_unit #(.CNT_W(2)) dut_w (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre_w), .PCSrc(PCSrc_w), .IRWre(IRWre_w), .RegWre(RegWre_w), .RegDst(RegDst_w),
    .ALUSrcB(ALUSrcB_w), .ALUOp(ALUOp_w), .ExtSel(ExtSel_w), .mRD(mRD_w), .mWR(mWR_w),
    .DBDataSrc(DBDataSrc_w), .state(state_w), .halted(halted_w), .instCount(instCount_w)
  );

  always #5 CLK = ~CLK;

  // {state, PCWre, PCSrc, IRWre, RegWre, mRD, mWR}
  wire [9:0] obs = {state, PCWre, PCSrc, IRWre, RegWre, mRD, mWR};
  // {RegDst, ALUSrcB, ALUOp, ExtSel, DBDataSrc}
  wire [6:0] dec = {RegDst, ALUSrcB, ALUOp, ExtSel, DBDataSrc};

  function automatic logic [9:0] pk(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                                    input logic ir, input logic rg, input logic rd,
                                    input logic wr);
    return {st, pw, ps, ir, rg, rd, wr};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step();
    step();
    n_total++;
    if (state !== 3'b000) $display("FAIL reset_state got %b want 000", state);
    else n_pass++;
    n_total++;
    if (IRWre !== 1'b0) $display("FAIL reset_irwre_forced got %b want 0", IRWre);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++;
    if (obs !== pk(3'd0, 0, 2'b00, 1, 0, 0, 0))
      $display("FAIL reset_release got %b want %b", obs, pk(3'd0, 0, 2'b00, 1, 0, 0, 0));
    else n_pass++;
    n_total++;
    if (instCount !== 16'd0) $display("FAIL reset_count got %0d want 0", instCount);
    else n_pass++;
  endtask

  task automatic test_alu();
    logic [5:0] ops [4];
    logic [6:0] decs [4];
    logic [9:0] seq [4];
    ops  = '{6'b000000, 6'b000001, 6'b000010, 6'b010010};
    decs = '{7'b1_0_000_1_0, 7'b1_0_001_1_0, 7'b0_1_000_1_0, 7'b0_1_011_0_0};
    seq  = '{pk(3'd0, 0, 2'b00, 1, 0, 0, 0), pk(3'd1, 0, 2'b00, 0, 0, 0, 0),
             pk(3'd2, 0, 2'b00, 0, 0, 0, 0), pk(3'd4, 1, 2'b00, 0, 1, 0, 0)};
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      #1;
      n_total++;
      if (dec !== decs[k]) $display("FAIL alu_decode op=%b got %b want %b", ops[k], dec, decs[k]);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (obs !== seq[i])
          $display("FAIL alu_seq op=%b cyc=%0d got %b want %b", ops[k], i, obs, seq[i]);
        else n_pass++;
        step();
      end
      exp_cnt++;
      n_total++;
      if (instCount !== 16'(exp_cnt))
        $display("FAIL alu_count got %0d want %0d", instCount, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_beq();
    logic [9:0] seq [3];
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b110100;
      zero   = z[0];
      seq = '{pk(3'd0, 0, 2'b00, 1, 0, 0, 0), pk(3'd1, 0, 2'b00, 0, 0, 0, 0),
              pk(3'd2, 1, (z == 1) ? 2'b01 : 2'b00, 0, 0, 0, 0)};
      #1;
      n_total++;
      if (ALUOp !== 3'b001) $display("FAIL beq_aluop got %b want 001", ALUOp);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (obs !== seq[i]) $display("FAIL beq_seq z=%0d cyc=%0d got %b want %b", z, i, obs, seq[i]);
        else n_pass++;
        step();
      end
      exp_cnt++;
      n_total++;
      if (state !== 3'b000 || instCount !== 16'(exp_cnt))
        $display("FAIL beq_end state=%b count=%0d want 000/%0d", state, instCount, exp_cnt);
      else n_pass++;
    end
    zero = 1'b0;
  endtask

  task automatic test_lw_sw();
    logic [9:0] lw_seq [5];
    logic [9:0] sw_seq [4];
    lw_seq = '{pk(3'd0, 0, 2'b00, 1, 0, 0, 0), pk(3'd1, 0, 2'b00, 0, 0, 0, 0),
               pk(3'd2, 0, 2'b00, 0, 0, 0, 0), pk(3'd3, 0, 2'b00, 0, 0, 1, 0),
               pk(3'd4, 1, 2'b00, 0, 1, 1, 0)};
    sw_seq = '{pk(3'd0, 0, 2'b00, 1, 0, 0, 0), pk(3'd1, 0, 2'b00, 0, 0, 0, 0),
               pk(3'd2, 0, 2'b00, 0, 0, 0, 0), pk(3'd3, 1, 2'b00, 0, 0, 0, 1)};
    opcode = 6'b110001;
    #1;
    n_total++;
    if (dec !== 7'b0_1_000_1_1) $display("FAIL lw_decode got %b want 0100011", dec);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (obs !== lw_seq[i]) $display("FAIL lw_seq cyc=%0d got %b want %b", i, obs, lw_seq[i]);
      else n_pass++;
      step();
    end
    opcode = 6'b110000;
    #1;
    n_total++;
    if (dec !== 7'b0_1_000_1_0) $display("FAIL sw_decode got %b want 0100010", dec);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (obs !== sw_seq[i]) $display("FAIL sw_seq cyc=%0d got %b want %b", i, obs, sw_seq[i]);
      else n_pass++;
      step();
    end
    exp_cnt += 2;
    n_total++;
    if (state !== 3'b000 || instCount !== 16'(exp_cnt))
      $display("FAIL lw_sw_end state=%b count=%0d want 000/%0d", state, instCount, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_jump_undef();
    logic [5:0] ops [2];
    logic [9:0] id_exp [2];
    ops    = '{6'b111000, 6'b101010};
    id_exp = '{pk(3'd1, 1, 2'b10, 0, 0, 0, 0), pk(3'd1, 1, 2'b00, 0, 0, 0, 0)};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      #1;
      n_total++;
      if (obs !== pk(3'd0, 0, 2'b00, 1, 0, 0, 0))
        $display("FAIL jmp_if op=%b got %b want 0000001000", ops[k], obs);
      else n_pass++;
      step();
      n_total++;
      if (obs !== id_exp[k]) $display("FAIL jmp_id op=%b got %b want %b", ops[k], obs, id_exp[k]);
      else n_pass++;
      step();
      exp_cnt++;
      n_total++;
      if (state !== 3'b000 || instCount !== 16'(exp_cnt))
        $display("FAIL jmp_end state=%b count=%0d want 000/%0d", state, instCount, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_wb();
    opcode = 6'b000000;
    step();
    step();
    step();
    n_total++;
    if (RegWre !== 1'b1 || state !== 3'b100)
      $display("FAIL rwb_pre state=%b regwre=%b want 100/1", state, RegWre);
    else n_pass++;
    Reset = 1'b0;
    #1;
    n_total++;
    if (RegWre !== 1'b0 || PCWre !== 1'b0 || PCSrc !== 2'b00)
      $display("FAIL rwb_forced regwre=%b pcwre=%b pcsrc=%b want 0/0/00", RegWre, PCWre, PCSrc);
    else n_pass++;
    step();
    n_total++;
    if (state !== 3'b000 || instCount !== 16'd0)
      $display("FAIL rwb_after state=%b count=%0d want 000/0", state, instCount);
    else n_pass++;
    Reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_wrap();
    logic [1:0] wexp [4];
    wexp = '{2'd1, 2'd2, 2'd3, 2'd0};
    opcode = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      step();
      step();
      exp_cnt++;
      n_total++;
      if (instCount_w !== wexp[k] || instCount !== 16'(exp_cnt))
        $display("FAIL wrap k=%0d got %0d/%0d want %0d/%0d", k, instCount_w, instCount,
                 wexp[k], exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    #1;
    n_total++;
    if (obs !== pk(3'd0, 0, 2'b00, 1, 0, 0, 0)) $display("FAIL halt_if got %b", obs);
    else n_pass++;
    step();
    n_total++;
    if (obs !== pk(3'd1, 0, 2'b00, 0, 0, 0, 0))
      $display("FAIL halt_id got %b want 0010000000", obs);
    else n_pass++;
    step();
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (obs !== pk(3'd5, 0, 2'b00, 0, 0, 0, 0) || halted !== 1'b1 ||
          instCount !== 16'(exp_cnt))
        $display("FAIL halt_hold cyc=%0d got %b halted=%b count=%0d want 1010000000/1/%0d",
                 i, obs, halted, instCount, exp_cnt);
      else n_pass++;
      step();
    end
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    #1;
    n_total++;
    if (state !== 3'b000 || halted !== 1'b0 || instCount !== 16'd0)
      $display("FAIL halt_exit state=%b halted=%b count=%0d want 000/0/0", state, halted,
               instCount);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_beq();
    test_lw_sw();
    test_jump_undef();
    test_reset_in_wb();
    test_wrap();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
